// File: rtl/sm_pkg.sv
// Shared constants for the sign-magnitude add/subtract pipeline.
package sm_pkg;

    // Operation select carried with each operand beat
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Default widths
    localparam int unsigned DATA_WIDTH_DEF = 4;
    localparam int unsigned CNT_WIDTH_DEF  = 16;

endpackage

// File: rtl/sm_addsub_core.sv
// Combinational sign-magnitude arithmetic.
// The compare group works on raw operands and feeds the first pipeline stage.
// The combine group works on the registered first-stage fields and produces the result.
module sm_addsub_core
    import sm_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
    // Compare group
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    input  logic                  op_i,
    output logic                  b_sign_eff_o,
    output logic                  a_gt_o,
    output logic                  a_eq_o,
    // Combine group
    input  logic                  a_sign_i,
    input  logic [DATA_WIDTH-2:0] a_mag_i,
    input  logic                  b_sign_i,
    input  logic [DATA_WIDTH-2:0] b_mag_i,
    input  logic                  a_gt_i,
    output logic [DATA_WIDTH:0]   sum_o
);

    localparam int unsigned MagW = DATA_WIDTH - 1;

    logic [MagW-1:0]       a_mag_raw;
    logic [MagW-1:0]       b_mag_raw;
    logic                  a_s;
    logic                  b_s;
    logic                  res_sign;
    logic [DATA_WIDTH-1:0] res_mag;

    // Effective B sign and magnitude compare on the raw operands
    always_comb begin
        a_mag_raw    = a_i[MagW-1:0];
        b_mag_raw    = b_i[MagW-1:0];
        b_sign_eff_o = b_i[DATA_WIDTH-1] ^ (op_i == OP_SUB);
        a_gt_o       = a_mag_raw > b_mag_raw;
        a_eq_o       = a_mag_raw == b_mag_raw;
    end

    // Add or subtract magnitudes; a zero magnitude never carries a minus sign
    always_comb begin
        a_s      = a_sign_i & (a_mag_i != '0);
        b_s      = b_sign_i & (b_mag_i != '0);
        res_sign = 1'b0;
        res_mag  = '0;
        if (a_s == b_s) begin
            res_mag  = {1'b0, a_mag_i} + {1'b0, b_mag_i};
            res_sign = a_s;
        end else if (a_gt_i) begin
            res_mag  = {1'b0, a_mag_i - b_mag_i};
            res_sign = a_s;
        end else begin
            res_mag  = {1'b0, b_mag_i - a_mag_i};
            res_sign = b_s;
        end
        if (res_mag == '0) begin
            res_sign = 1'b0;
        end
        sum_o = {res_sign, res_mag};
    end

endmodule

// File: rtl/sm_addsub_pipe.sv
// Two-stage valid/ready pipeline around the sign-magnitude add/subtract core,
// with a count of results handed downstream.
module sm_addsub_pipe
    import sm_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned CNT_WIDTH  = CNT_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  op,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH:0]   sum,
    output logic                  mag_eq,
    output logic [CNT_WIDTH-1:0]  result_cnt
);

    localparam int unsigned MagW = DATA_WIDTH - 1;

    // Stage 1
    logic            s1_valid_q;
    logic            s1_a_sign_q;
    logic [MagW-1:0] s1_a_mag_q;
    logic            s1_b_sign_q;
    logic [MagW-1:0] s1_b_mag_q;
    logic            s1_a_gt_q;
    logic            s1_a_eq_q;

    // Stage 2
    logic                s2_valid_q;
    logic [DATA_WIDTH:0] sum_q;
    logic                mag_eq_q;

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    logic                b_sign_eff;
    logic                a_gt;
    logic                a_eq;
    logic [DATA_WIDTH:0] core_sum;
    logic                s1_adv;
    logic                s2_adv;

    sm_addsub_core #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_core (
        .a_i          (a),
        .b_i          (b),
        .op_i         (op),
        .b_sign_eff_o (b_sign_eff),
        .a_gt_o       (a_gt),
        .a_eq_o       (a_eq),
        .a_sign_i     (s1_a_sign_q),
        .a_mag_i      (s1_a_mag_q),
        .b_sign_i     (s1_b_sign_q),
        .b_mag_i      (s1_b_mag_q),
        .a_gt_i       (s1_a_gt_q),
        .sum_o        (core_sum)
    );

    // Stage-advance conditions, input handshake and next counter value
    always_comb begin
        s2_adv   = !s2_valid_q || out_ready;
        s1_adv   = !s1_valid_q || s2_adv;
        in_ready = s1_adv && !rst;
        cnt_d    = cnt_q;
        if (s2_valid_q && out_ready) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    // Pipeline registers and result counter
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_a_sign_q <= 1'b0;
            s1_a_mag_q  <= '0;
            s1_b_sign_q <= 1'b0;
            s1_b_mag_q  <= '0;
            s1_a_gt_q   <= 1'b0;
            s1_a_eq_q   <= 1'b0;
            s2_valid_q  <= 1'b0;
            sum_q       <= '0;
            mag_eq_q    <= 1'b0;
            cnt_q       <= '0;
        end else begin
            if (s1_adv) begin
                s1_valid_q <= in_valid;
                if (in_valid) begin
                    s1_a_sign_q <= a[DATA_WIDTH-1];
                    s1_a_mag_q  <= a[MagW-1:0];
                    s1_b_sign_q <= b_sign_eff;
                    s1_b_mag_q  <= b[MagW-1:0];
                    s1_a_gt_q   <= a_gt;
                    s1_a_eq_q   <= a_eq;
                end
            end
            if (s2_adv) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    sum_q    <= core_sum;
                    mag_eq_q <= s1_a_eq_q;
                end
            end
            cnt_q <= cnt_d;
        end
    end

    assign out_valid  = s2_valid_q;
    assign sum        = sum_q;
    assign mag_eq     = mag_eq_q;
    assign result_cnt = cnt_q;

endmodule
